// File: rtl/display_arbiter.sv
// -----------------------------------------------------------------------------
// display_arbiter
//
// Round-robin arbiter that hands a two-byte numeric display to one of four
// requesters at a time. The winner's 16-bit value is frozen into a hold
// register and shown for HOLD_CYCLES clocks (or until the owner withdraws
// its request), after which the owner receives a one-cycle Done pulse and
// the search pointer moves past it.
//
// Ports
//   Clk      in   system clock, rising-edge
//   Rst_n    in   asynchronous active-low reset
//   Req      in   [3:0]  per-requester display request
//   DataIn   in   [63:0] requester i value in DataIn[16i+15:16i]
//   Grant    out  [3:0]  one-hot current owner, zero when nobody shows
//   Done     out  [3:0]  one-cycle pulse to the owner on hold completion
//   NumberA  out  high byte of the held value (left digit pair)
//   NumberB  out  low byte of the held value (right digit pair)
//   Blank    out  high when no owner; qualifies NumberA/NumberB
//   Owner    out  [1:0]  index of the current or last owner
//   Busy     out  high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module display_arbiter #(
  parameter int NUM_WIDTH   = 8,
  parameter int HOLD_CYCLES = 100000000
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic [3:0]           Req,
  input  logic [63:0]          DataIn,
  output logic [3:0]           Grant,
  output logic [3:0]           Done,
  output logic [NUM_WIDTH-1:0] NumberA,
  output logic [NUM_WIDTH-1:0] NumberB,
  output logic                 Blank,
  output logic [1:0]           Owner,
  output logic                 Busy
);

  // A single-cycle hold still needs a one-bit timer to exist.
  localparam int TIMER_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    SHOW    = 2'd2,
    RELEASE = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         ptr_q,   ptr_d;
  logic [1:0]         win_q,   win_d;
  logic [1:0]         owner_q, owner_d;
  logic [15:0]        hold_q,  hold_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [3:0]         grant_q, grant_d;
  logic [3:0]         done_q,  done_d;

  logic [1:0]         rr_win;

  // Round-robin search: P, P+1, P+2, P+3 (mod 4); first set bit wins.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    found  = 1'b0;
    idx    = '0;
    rr_win = ptr_q;
    for (int i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && Req[idx]) begin
        found  = 1'b1;
        rr_win = idx;
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; that is what keeps this block free of inferred latches.
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    owner_d = owner_q;
    hold_d  = hold_q;
    timer_d = timer_q;
    grant_d = grant_q;
    done_d  = '0;

    unique case (state_q)
      IDLE: begin
        grant_d = '0;
        if (|Req) begin
          win_d   = rr_win;
          state_d = LOAD;
        end
      end

      LOAD: begin
        // Capture the winner's slice now; it stays frozen for the whole SHOW.
        hold_d  = DataIn[{win_q, 4'b0000} +: 16];
        owner_d = win_q;
        timer_d = TIMER_LOAD;
        grant_d = 4'b0001 << win_q;
        state_d = SHOW;
      end

      SHOW: begin
        // A withdrawn request ends the hold early and forfeits Done, even
        // on the cycle the timer would have expired.
        if (!Req[owner_q]) begin
          grant_d = '0;
          state_d = RELEASE;
        end else if (timer_q == '0) begin
          grant_d = '0;
          done_d  = 4'b0001 << owner_q;
          state_d = RELEASE;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end

      RELEASE: begin
        ptr_d   = owner_q + 2'd1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  // NOTE: the hold register is a plain register, not a memory array, so it is
  // reset along with everything else and NumberA/NumberB read zero after reset.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      owner_q <= '0;
      hold_q  <= '0;
      timer_q <= '0;
      grant_q <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      owner_q <= owner_d;
      hold_q  <= hold_d;
      timer_q <= timer_d;
      grant_q <= grant_d;
      done_q  <= done_d;
    end
  end

  // Numbers come straight from the hold register, which only changes on the
  // LOAD->SHOW edge, so they keep their last values outside SHOW.
  assign NumberA = NUM_WIDTH'(hold_q[15:8]);
  assign NumberB = NUM_WIDTH'(hold_q[7:0]);
  assign Grant   = grant_q;
  assign Done    = done_q;
  assign Owner   = owner_q;
  assign Blank   = (state_q != SHOW);
  assign Busy    = (state_q != IDLE);

endmodule

// File: tb/tb_display_arbiter.sv
// -----------------------------------------------------------------------------
// tb_display_arbiter
//
// Directed bench for display_arbiter with HOLD_CYCLES=4. The driver issues
// requests and pushes the expected grant record (owner, displayed bytes,
// visible SHOW length, Done pattern) into a queue; a monitor on the falling
// edge pops a record whenever a new Grant appears and checks it through to
// the release cycle.
// -----------------------------------------------------------------------------
module tb_display_arbiter;

  localparam int HOLD = 4;

  logic        Clk;
  logic        Rst_n;
  logic [3:0]  Req;
  logic [63:0] DataIn;
  logic [3:0]  Grant;
  logic [3:0]  Done;
  logic [7:0]  NumberA;
  logic [7:0]  NumberB;
  logic        Blank;
  logic [1:0]  Owner;
  logic        Busy;

  display_arbiter #(
    .NUM_WIDTH  (8),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .Clk    (Clk),
    .Rst_n  (Rst_n),
    .Req    (Req),
    .DataIn (DataIn),
    .Grant  (Grant),
    .Done   (Done),
    .NumberA(NumberA),
    .NumberB(NumberB),
    .Blank  (Blank),
    .Owner  (Owner),
    .Busy   (Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [3:0] grant;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] owner;
    int         len;
    logic [3:0] done;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_grant(input logic [1:0] owner, input logic [15:0] val,
                              input int len, input logic done_en);
    exp_t e;
    e.grant = 4'b0001 << owner;
    e.a     = val[15:8];
    e.b     = val[7:0];
    e.owner = owner;
    e.len   = len;
    e.done  = done_en ? (4'b0001 << owner) : 4'b0000;
    exp_q.push_back(e);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_grant"}, 32'(Grant),   32'h0);
    check({tag, "_done"},  32'(Done),    32'h0);
    check({tag, "_numa"},  32'(NumberA), 32'h0);
    check({tag, "_numb"},  32'(NumberB), 32'h0);
    check({tag, "_owner"}, 32'(Owner),   32'h0);
    check({tag, "_busy"},  32'(Busy),    32'h0);
    check({tag, "_blank"}, 32'(Blank),   32'h1);
  endtask

  task automatic wait_grant(input int budget);
    int n = 0;
    do begin
      @(posedge Clk); #1;
      n++;
    end while (Grant == 4'b0000 && n < budget);
    check("grant_wait", 32'(Grant != 4'b0000), 32'h1);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    do begin
      @(posedge Clk); #1;
      n++;
    end while (Done == 4'b0000 && n < budget);
    check("done_wait", 32'(Done != 4'b0000), 32'h1);
  endtask

  // Monitor: new Grant -> pop and check; each SHOW cycle -> frozen values;
  // Grant falling -> check visible length, Done and Blank.
  exp_t cur;
  bit   active   = 1'b0;
  int   show_len = 0;

  always @(negedge Clk) begin
    if (!active && Grant != 4'b0000) begin
      if (exp_q.size() == 0) begin
        check("unexpected_grant", 32'(Grant), 32'h0);
      end else begin
        cur      = exp_q.pop_front();
        active   = 1'b1;
        show_len = 1;
        check("start_grant", 32'(Grant),   32'(cur.grant));
        check("start_owner", 32'(Owner),   32'(cur.owner));
        check("start_numa",  32'(NumberA), 32'(cur.a));
        check("start_numb",  32'(NumberB), 32'(cur.b));
        check("start_blank", 32'(Blank),   32'h0);
      end
    end else if (active && Grant != 4'b0000) begin
      show_len++;
      check("show_grant", 32'(Grant),   32'(cur.grant));
      check("show_numa",  32'(NumberA), 32'(cur.a));
      check("show_numb",  32'(NumberB), 32'(cur.b));
    end else if (active) begin
      active = 1'b0;
      check("show_len",  32'(show_len), 32'(cur.len));
      check("end_done",  32'(Done),     32'(cur.done));
      check("end_blank", 32'(Blank),    32'h1);
    end else if (Done != 4'b0000) begin
      check("spurious_done", 32'(Done), 32'h0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Rst_n  = 1'b0;
    Req    = 4'b0000;
    DataIn = '0;
    #2;
    reset_checks("rst_init");
    #10;
    Rst_n = 1'b1;

    // Single request, latency and 4-cycle hold.
    @(posedge Clk); #1;
    DataIn[15:0] = 16'hA55A;
    Req          = 4'b0001;
    expect_grant(2'd0, 16'hA55A, HOLD, 1'b1);
    @(posedge Clk);
    @(posedge Clk); #1;
    check("lat_grant", 32'(Grant),   32'h1);
    check("lat_blank", 32'(Blank),   32'h0);
    check("lat_numa",  32'(NumberA), 32'hA5);
    wait_done(20);
    Req = 4'b0000;
    repeat (2) begin @(posedge Clk); #1; end
    check("single_idle_busy", 32'(Busy), 32'h0);

    // Mid-cycle reset in IDLE returns the pointer to 0 and clears the bytes.
    @(posedge Clk); #3;
    Rst_n = 1'b0;
    #1;
    reset_checks("rst_mid");
    @(negedge Clk); #2;
    Rst_n = 1'b1;

    // Round-robin with every request held: owners 0,1,2,3,0.
    @(posedge Clk); #1;
    DataIn = {16'h3A3B, 16'h2A2B, 16'h1A1B, 16'h0A0B};
    Req    = 4'b1111;
    for (int i = 0; i < 5; i++)
      expect_grant(2'(i), DataIn[16*(i%4) +: 16], HOLD, 1'b1);
    for (int i = 0; i < 5; i++) wait_done(20);
    Req = 4'b0000;

    // Freeze: DataIn changes during requester 1's SHOW must not show.
    @(posedge Clk); #1;
    DataIn[31:16] = 16'h1234;
    Req           = 4'b0010;
    expect_grant(2'd1, 16'h1234, HOLD, 1'b1);
    wait_grant(10);
    DataIn[31:16] = 16'hFFFF;
    wait_done(20);
    Req = 4'b0000;

    // Abort: drop Req[2] in the second SHOW cycle; no Done, pointer -> 3.
    @(posedge Clk); #1;
    DataIn[47:32] = 16'hBEEF;
    Req           = 4'b0100;
    expect_grant(2'd2, 16'hBEEF, 2, 1'b0);
    wait_grant(10);
    @(posedge Clk); #1;
    Req = 4'b0000;
    repeat (3) begin @(posedge Clk); #1; end
    check("abort_idle_busy", 32'(Busy), 32'h0);
    DataIn[63:48] = 16'hCAFE;
    DataIn[15:0]  = 16'h0F0F;
    Req           = 4'b1001;
    expect_grant(2'd3, 16'hCAFE, HOLD, 1'b1);
    wait_done(20);
    Req = 4'b0000;

    // Move the pointer to 1, then reset in the middle of requester 1's SHOW.
    @(posedge Clk); #1;
    Req = 4'b0001;
    expect_grant(2'd0, 16'h0F0F, HOLD, 1'b1);
    wait_done(20);
    Req = 4'b0000;
    @(posedge Clk); #1;
    DataIn[31:16] = 16'h5AA5;
    Req           = 4'b0010;
    expect_grant(2'd1, 16'h5AA5, 1, 1'b0);
    wait_grant(10);
    @(negedge Clk); #2;
    Rst_n = 1'b0;
    #1;
    reset_checks("rst_show");
    Req = 4'b1001;
    @(negedge Clk); #2;
    Rst_n = 1'b1;
    // Pointer is back at 0, so requester 0 beats requester 3.
    expect_grant(2'd0, 16'h0F0F, HOLD, 1'b1);
    wait_done(20);
    Req = 4'b0000;
    @(posedge Clk); #1;
    Req = 4'b1000;
    expect_grant(2'd3, 16'hCAFE, HOLD, 1'b1);
    wait_done(20);
    Req = 4'b0000;

    repeat (5) @(posedge Clk);
    #1;
    check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/display_arbiter.md
DISPLAY_ARBITER -- requirements
Module: display_arbiter

Interface
REQ-001 The block SHALL have the parameter NUM_WIDTH, default 8, meaning the width of each displayed byte field (NumberA, NumberB).
REQ-002 The block SHALL have the parameter HOLD_CYCLES, default 100000000, meaning the number of Clk cycles one grant owns the display (1 s at 100 MHz).
REQ-003 The block SHALL have the port Clk, input, 1 bit: the single system clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have the port Rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have the port Req, input, 4 bits: Req[i] high means requester i wants the display.
REQ-006 The block SHALL have the port DataIn, input, 64 bits: requester i value is DataIn[16i+15:16i].
REQ-007 The block SHALL have the port Grant, output, 4 bits: registered, one-hot or zero; marks the current display owner.
REQ-008 The block SHALL have the port Done, output, 4 bits: registered; one-cycle pulse to the owner when its hold time completes.
REQ-009 The block SHALL have the port NumberA, output, NUM_WIDTH bits: the high byte of the held value, feeding the left digit pair.
REQ-010 The block SHALL have the port NumberB, output, NUM_WIDTH bits: the low byte of the held value, feeding the right digit pair.
REQ-011 The block SHALL have the port Blank, output, 1 bit: high when no owner; downstream forces all digit enables off.
REQ-012 The block SHALL have the port Owner, output, 2 bits: binary index of the current or last owner.
REQ-013 The block SHALL have the port Busy, output, 1 bit: high in every state except IDLE.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, LOAD, SHOW, RELEASE.
REQ-015 IDLE: if Req is nonzero, the FSM SHALL select a winner by round-robin and go to LOAD; otherwise it SHALL stay in IDLE with Blank=1 and Grant=0.
REQ-016 Round-robin: the search SHALL start at pointer P and proceed P, P+1, P+2, P+3 (mod 4); the first set Req bit wins.
REQ-017 LOAD (one cycle): the winner's 16-bit DataIn slice SHALL be captured into the hold register, the winner index into Owner, the timer loaded with HOLD_CYCLES-1, and the FSM SHALL go to SHOW.
REQ-018 Latency: a Req sampled high in IDLE at edge k SHALL produce Grant, Blank=0 and new NumberA/NumberB valid after edge k+1.
REQ-019 SHOW: Grant[Owner]=1, Blank=0, NumberA=hold[15:8], NumberB=hold[7:0]; DataIn changes SHALL NOT affect the outputs (value frozen).
REQ-020 SHOW SHALL last exactly HOLD_CYCLES cycles; at timer==0 the FSM SHALL go to RELEASE with Done[Owner] pulsed high for the RELEASE cycle.
REQ-021 Abort: if Req[Owner] is sampled low during SHOW, the FSM SHALL go to RELEASE on that edge and Done SHALL stay 0.
REQ-022 RELEASE (one cycle): Grant=0, Blank=1, P=(Owner+1) mod 4; the FSM SHALL then go to IDLE, with no new grant before the following IDLE evaluation.
REQ-023 The timer SHALL be ceil(log2(HOLD_CYCLES)) bits wide and SHALL never wrap; HOLD_CYCLES=1 SHALL give a one-cycle SHOW.
REQ-024 Non-owner Req changes during LOAD, SHOW or RELEASE SHALL be ignored until the next IDLE.
REQ-025 Outside SHOW, NumberA and NumberB SHALL hold their last values; Blank qualifies them.

Reset
REQ-026 Rst_n low SHALL immediately, without a clock edge, force: state=IDLE, P=0, hold=0, timer=0, Grant=0, Done=0, NumberA=0, NumberB=0, Owner=0, Busy=0, Blank=1.
REQ-027 Reset during any state, including mid-SHOW, SHALL discard the grant with no Done pulse; operation SHALL resume at the first edge after Rst_n rises.

Verification (bench uses HOLD_CYCLES=4)
REQ-028 Reset: assert Rst_n=0 mid-cycle -> all outputs at REQ-026 values before the next Clk edge.
REQ-029 Single request: Req=4'b0001, DataIn[15:0]=16'hA55A -> after 2 edges Grant=0001, NumberA=8'hA5, NumberB=8'h5A, Blank=0 for exactly 4 cycles, then Done=0001 for 1 cycle, then IDLE.
REQ-030 Round-robin: Req=4'b1111 held -> Owner sequence 0,1,2,3,0, each with a Done pulse.
REQ-031 Freeze: change DataIn[31:16] from 16'h1234 to 16'hFFFF during requester 1's SHOW -> NumberA/NumberB stay 8'h12/8'h34.
REQ-032 Abort: drop Req[2] in the second SHOW cycle -> RELEASE next edge, Done=0, next search starts at requester 3.
REQ-033 Reset mid-SHOW: Rst_n=0 during SHOW -> Grant=0 and Blank=1 immediately; after release, Req=4'b1000 is granted to requester 3 via the P=0 search.
